// File: rtl/forwarding_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : forwarding_hazard_unit
// Description : Control side of the EX-stage operand forwarding for a 5-stage
//               MIPS pipeline. Keeps shadow copies of the EX/MEM and MEM/WB
//               destination info and drives the operand A/B forward selects.
//               Detects load-use hazards and drives the stall/bubble controls.
//               Keeps saturating stall and forward event counters.
// Ports       : clk, reset       - clock (rising edge), async active-high reset
//               id_rs/id_rt/id_valid
//                                 - source regs of the ID-stage instruction
//               ex_rs/ex_rt/ex_dst/ex_regwrite/ex_memread/ex_valid
//                                 - fields of the EX-stage instruction
//               flush             - branch/jump flush of IF/ID and ID/EX
//               forward_a/_b      - 00 ID/EX, 10 EX/MEM, 01 MEM/WB
//               stall, bubble     - hold PC + IF/ID, insert NOP into ID/EX
//               stall_count, fwd_count - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module forwarding_hazard_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] ex_dst,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic                  ex_valid,
    input  logic                  flush,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall,
    output logic                  bubble,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      fwd_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [1:0]       c_FWD_NONE  = 2'b00;
    localparam logic [1:0]       c_FWD_MEM   = 2'b10;
    localparam logic [1:0]       c_FWD_WB    = 2'b01;
    localparam logic             c_MULTI     = (LOAD_STALL_CYCLES > 1);
    localparam logic [2:0]       c_HOLD_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    logic [REG_ADDR_W-1:0] r_memDst;
    logic                  r_memWe;
    logic [REG_ADDR_W-1:0] r_wbDst;
    logic                  r_wbWe;
    state_t                r_state;
    logic [2:0]            r_rem;
    logic [CNT_W-1:0]      r_stallCnt;
    logic [CNT_W-1:0]      r_fwdCnt;

    logic [1:0]            w_fwdA;
    logic [1:0]            w_fwdB;
    logic                  w_hazard;
    logic                  w_stall;
    logic                  w_anyFwd;

    // Shadow destination pipe: always advances, independent of stall/flush,
    // because the real EX/MEM and MEM/WB registers are never frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memDst <= '0;
            r_memWe  <= 1'b0;
            r_wbDst  <= '0;
            r_wbWe   <= 1'b0;
        end else begin
            r_memDst <= ex_dst;
            r_memWe  <= ex_regwrite & ex_valid;
            r_wbDst  <= r_memDst;
            r_wbWe   <= r_memWe;
        end
    end

    // Forward selects: the younger EX/MEM result wins over MEM/WB; r0 is
    // hard-wired zero and must never be forwarded.
    always_comb begin
        w_fwdA = c_FWD_NONE;
        w_fwdB = c_FWD_NONE;
        if (r_memWe && (r_memDst != '0) && (r_memDst == ex_rs)) begin
            w_fwdA = c_FWD_MEM;
        end else if (r_wbWe && (r_wbDst != '0) && (r_wbDst == ex_rs)) begin
            w_fwdA = c_FWD_WB;
        end
        if (r_memWe && (r_memDst != '0) && (r_memDst == ex_rt)) begin
            w_fwdB = c_FWD_MEM;
        end else if (r_wbWe && (r_wbDst != '0) && (r_wbDst == ex_rt)) begin
            w_fwdB = c_FWD_WB;
        end
    end

    assign w_hazard = id_valid & ex_valid & ex_memread & (ex_dst != '0)
                    & ((ex_dst == id_rs) | (ex_dst == id_rt));

    // Stall must react in the same cycle as the hazard, so it is decoded
    // from state and inputs rather than registered. Reset gates it directly
    // so an asynchronous reset drops the stall before the next edge.
    always_comb begin
        w_stall = 1'b0;
        if (!reset && !flush) begin
            if (r_state == HOLD) begin
                w_stall = 1'b1;
            end else begin
                w_stall = w_hazard;
            end
        end
    end

    // HOLD covers the extra cycles of a multi-cycle load; the first stall
    // cycle is always produced from IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_rem   <= 3'd0;
        end else if (flush) begin
            r_state <= IDLE;
            r_rem   <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hazard && c_MULTI) begin
                        r_state <= HOLD;
                        r_rem   <= c_HOLD_INIT;
                    end
                end
                HOLD: begin
                    r_rem <= r_rem - 3'd1;
                    if (r_rem == 3'd1) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rem   <= 3'd0;
                end
            endcase
        end
    end

    assign w_anyFwd = (w_fwdA != c_FWD_NONE) | (w_fwdB != c_FWD_NONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallCnt <= '0;
            r_fwdCnt   <= '0;
        end else begin
            if (w_stall && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + c_CNT_ONE;
            end
            if (w_anyFwd && (r_fwdCnt != '1)) begin
                r_fwdCnt <= r_fwdCnt + c_CNT_ONE;
            end
        end
    end

    assign forward_a   = w_fwdA;
    assign forward_b   = w_fwdB;
    assign stall       = w_stall;
    assign bubble      = w_stall;
    assign stall_count = r_stallCnt;
    assign fwd_count   = r_fwdCnt;

endmodule
`default_nettype wire

// File: tb/tb_forwarding_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_forwarding_hazard_unit
// Description : Scoreboard bench for forwarding_hazard_unit. Three instances
//               share the stimulus: default (1-cycle load stall), a 3-cycle
//               load stall variant, and a 4-bit counter variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forwarding_hazard_unit;

    logic       clk;
    logic       reset;
    logic [4:0] idRs, idRt, exRs, exRt, exDst;
    logic       idValid, exRegwrite, exMemread, exValid, flush;

    logic [1:0]  fa1, fb1, fa3, fb3, fa4, fb4;
    logic        st1, bu1, st3, bu3, st4, bu4;
    logic [15:0] sc1, fc1, sc3, fc3;
    logic [3:0]  sc4, fc4;

    forwarding_hazard_unit u_d1 (
        .clk(clk), .reset(reset), .id_rs(idRs), .id_rt(idRt), .id_valid(idValid),
        .ex_rs(exRs), .ex_rt(exRt), .ex_dst(exDst), .ex_regwrite(exRegwrite),
        .ex_memread(exMemread), .ex_valid(exValid), .flush(flush),
        .forward_a(fa1), .forward_b(fb1), .stall(st1), .bubble(bu1),
        .stall_count(sc1), .fwd_count(fc1)
    );

    forwarding_hazard_unit #(.LOAD_STALL_CYCLES(3)) u_d3 (
        .clk(clk), .reset(reset), .id_rs(idRs), .id_rt(idRt), .id_valid(idValid),
        .ex_rs(exRs), .ex_rt(exRt), .ex_dst(exDst), .ex_regwrite(exRegwrite),
        .ex_memread(exMemread), .ex_valid(exValid), .flush(flush),
        .forward_a(fa3), .forward_b(fb3), .stall(st3), .bubble(bu3),
        .stall_count(sc3), .fwd_count(fc3)
    );

    forwarding_hazard_unit #(.CNT_W(4)) u_d4 (
        .clk(clk), .reset(reset), .id_rs(idRs), .id_rt(idRt), .id_valid(idValid),
        .ex_rs(exRs), .ex_rt(exRt), .ex_dst(exDst), .ex_regwrite(exRegwrite),
        .ex_memread(exMemread), .ex_valid(exValid), .flush(flush),
        .forward_a(fa4), .forward_b(fb4), .stall(st4), .bubble(bu4),
        .stall_count(sc4), .fwd_count(fc4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } sbEntry_t;

    sbEntry_t sb[$];
    int       errors = 0;
    int       checks = 0;

    // Expected counter values, accumulated from the bench's own expectations
    int eFwd, eFwd4, eSt1, eSt3, eSt4;

    string sigName[17] = '{"fa1", "fb1", "st1", "bu1", "fa3", "fb3", "st3", "bu3",
                           "sc1", "fc1", "sc3", "fc3", "sc4", "fc4", "fa4", "fb4", "st4"};

    function automatic logic [31:0] actual(input int s);
        case (s)
            0:  return 32'(fa1);
            1:  return 32'(fb1);
            2:  return 32'(st1);
            3:  return 32'(bu1);
            4:  return 32'(fa3);
            5:  return 32'(fb3);
            6:  return 32'(st3);
            7:  return 32'(bu3);
            8:  return 32'(sc1);
            9:  return 32'(fc1);
            10: return 32'(sc3);
            11: return 32'(fc3);
            12: return 32'(sc4);
            13: return 32'(fc4);
            14: return 32'(fa4);
            15: return 32'(fb4);
            default: return 32'(st4);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int sig, input int val);
        sbEntry_t e;
        e.tag = $sformatf("%s.%s", tag, sigName[sig]);
        e.sig = sig;
        e.val = 32'(val);
        sb.push_back(e);
    endtask

    task automatic pushAll(input string tag, input int fa, input int fb, input int s1, input int s3);
        push(tag, 0, fa);  push(tag, 1, fb);  push(tag, 2, s1);  push(tag, 3, s1);
        push(tag, 4, fa);  push(tag, 5, fb);  push(tag, 6, s3);  push(tag, 7, s3);
        push(tag, 14, fa); push(tag, 15, fb); push(tag, 16, s1);
        push(tag, 8, eSt1); push(tag, 9, eFwd); push(tag, 10, eSt3); push(tag, 11, eFwd);
        push(tag, 12, eSt4); push(tag, 13, eFwd4);
    endtask

    task automatic drain();
        sbEntry_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, actual(e.sig), e.val);
        end
    endtask

    task automatic clearModel();
        eFwd = 0; eFwd4 = 0; eSt1 = 0; eSt3 = 0; eSt4 = 0;
    endtask

    task automatic setEx(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                         input logic we, input logic mr, input logic v);
        exRs = rs; exRt = rt; exDst = dst; exRegwrite = we; exMemread = mr; exValid = v;
    endtask

    task automatic setId(input logic [4:0] rs, input logic [4:0] rt, input logic v);
        idRs = rs; idRt = rt; idValid = v;
    endtask

    task automatic idle();
        setEx(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        setId(5'd0, 5'd0, 1'b0);
        flush = 1'b0;
    endtask

    task automatic hazard();
        setEx(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1);
        setId(5'd0, 5'd4, 1'b1);
    endtask

    // One pipeline cycle: inputs already driven, expectations queued now,
    // compared at the falling edge, then the model counters advance.
    task automatic step(input string tag, input int fa, input int fb, input int s1, input int s3);
        pushAll(tag, fa, fb, s1, s3);
        @(negedge clk);
        drain();
        if (fa != 0 || fb != 0) begin
            eFwd++;
            if (eFwd4 != 15) eFwd4++;
        end
        eSt1 += s1;
        eSt3 += s3;
        if (s1 != 0 && eSt4 != 15) eSt4++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        clearModel();
        idle();
        reset = 1'b1;
        hazard();
        // Outputs stay quiet while reset is held, even with a hazard present
        @(negedge clk);
        pushAll("inReset", 0, 0, 0, 0);
        drain();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();

        // EX/MEM forwarding
        setEx(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);  step("exmemW", 0, 0, 0, 0);
        setEx(5'd8, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1);  step("exmemF", 2, 0, 0, 0);
        idle();                                     step("idle1", 0, 0, 0, 0);

        // MEM/WB forwarding and EX/MEM priority
        setEx(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);  step("wbW8", 0, 0, 0, 0);
        setEx(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1);  step("wbW9", 0, 0, 0, 0);
        setEx(5'd8, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1);  step("wbF", 1, 2, 0, 0);
        setEx(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);  step("priW1", 0, 0, 0, 0);
        setEx(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);  step("priW2", 0, 0, 0, 0);
        setEx(5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);  step("priF", 2, 0, 0, 0);

        // r0 is never forwarded; a bubble never writes
        setEx(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);  step("r0W", 0, 0, 0, 0);
        setEx(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);  step("r0F", 0, 0, 0, 0);
        setEx(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);  step("bubW", 0, 0, 0, 0);
        setEx(5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);  step("bubMem", 0, 0, 0, 0);
        setEx(5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);  step("bubWb", 0, 0, 0, 0);

        // Load-use: 1 stall cycle on u_d1, 3 on u_d3
        idle(); hazard();                           step("lu1", 0, 0, 1, 1);
        idle(); setId(5'd0, 5'd4, 1'b1);            step("lu2", 0, 0, 0, 1);
        idle(); setEx(5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1);
                                                    step("lu3", 0, 1, 0, 1);
        idle();                                     step("lu4", 0, 0, 0, 0);

        // Flush in the second stall cycle, then hazard and flush together
        hazard();                                   step("fl1", 0, 0, 1, 1);
        hazard(); flush = 1'b1;                     step("fl2", 0, 0, 0, 0);
        idle();                                     step("fl3", 0, 0, 0, 0);
        hazard(); flush = 1'b1;                     step("fl4", 0, 0, 0, 0);
        idle();                                     step("fl5", 0, 0, 0, 0);

        // Asynchronous reset in the middle of a HOLD
        hazard();                                   step("rh1", 0, 0, 1, 1);
        idle();                                     step("rh2", 0, 0, 0, 1);
        #1;
        push("rhPre", 6, 1);
        drain();
        #1;
        reset = 1'b1;
        #1;
        clearModel();
        pushAll("rhRst", 0, 0, 0, 0);
        drain();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Forward counter saturation on the 4-bit instance
        setEx(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);  step("satPre", 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            setEx(5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);
            step($sformatf("sat%0d", i), 2, 0, 0, 0);
        end
        idle();                                     step("satEnd", 0, 0, 0, 0);
        push("satFc4", 13, 15);
        push("satFc1", 9, 20);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Control-side counterpart of the EX-stage operand forwarding muxes in the 5-stage MIPS pipeline.
- Keeps its own shadow copies of the EX/MEM and MEM/WB destination info and drives the 2-bit selectors for operands A and B.
- Detects load-use hazards and generates the stall/bubble controls for the PC, IF/ID and ID/EX registers.
- Keeps saturating event counters for performance debug.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- LOAD_STALL_CYCLES, 1, stall cycles per load-use hazard (1..7; >1 for multi-cycle data memory).
- CNT_W, 16, width of the saturating event counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs  in  REG_ADDR_W  rs of the instruction in ID (IF/ID output).
- id_rt  in  REG_ADDR_W  rt of the instruction in ID.
- id_valid  in  1  ID holds a real instruction.
- ex_rs  in  REG_ADDR_W  rs of the instruction in EX (ID/EX output).
- ex_rt  in  REG_ADDR_W  rt of the instruction in EX.
- ex_dst  in  REG_ADDR_W  final destination register of the EX instruction (after RegDst select).
- ex_regwrite  in  1  EX instruction writes the register file.
- ex_memread  in  1  EX instruction is a load.
- ex_valid  in  1  EX holds a real instruction (0 = bubble).
- flush  in  1  branch/jump flush of IF/ID and ID/EX.
- forward_a  out  2  operand A mux select: 00 ID/EX, 10 EX/MEM, 01 MEM/WB.
- forward_b  out  2  operand B mux select, same encoding.
- stall  out  1  hold PC and IF/ID this cycle.
- bubble  out  1  load a NOP into ID/EX this cycle.
- stall_count  out  CNT_W  total stall cycles, saturating.
- fwd_count  out  CNT_W  total cycles with any nonzero forward select, saturating.

Behaviour:
- Shadow pipe, updated every rising clk:
  - mem_dst/mem_we <= ex_dst / (ex_regwrite & ex_valid).
  - wb_dst/wb_we <= mem_dst/mem_we.
  - Shadow pipe is never frozen by stall and is not cleared by flush; EX/MEM and MEM/WB always advance.
- Forward select, combinational from ex_rs/ex_rt and shadow registers (zero latency):
  - 10 if mem_we, mem_dst != 0 and mem_dst == source.
  - Else 01 if wb_we, wb_dst != 0 and wb_dst == source.
  - Else 00.
  - EX/MEM has priority over MEM/WB when both match.
  - Register 0 is never forwarded.
  - Encoding 11 is never driven.
- Hazard detect, combinational:
  - hz = id_valid & ex_valid & ex_memread & (ex_dst != 0) & (ex_dst == id_rs | ex_dst == id_rt).
- Stall FSM, states IDLE and HOLD, with remaining-cycle counter rem (3 bits):
  - IDLE: stall = bubble = hz & ~flush. If that is 1 and LOAD_STALL_CYCLES > 1: go to HOLD, rem <= LOAD_STALL_CYCLES-1.
  - HOLD: stall = bubble = 1, rem decrements each cycle; go to IDLE on the clock where rem == 1.
  - flush in any state: stall = bubble = 0, next state IDLE, rem <= 0. Flush beats hazard.
  - With LOAD_STALL_CYCLES = 1, the FSM never leaves IDLE. The hazard drops by itself next cycle because ID/EX then holds a bubble.
- Counters:
  - stall_count +1 on every clock where stall = 1.
  - fwd_count +1 on every clock where forward_a != 00 or forward_b != 00.
  - Both saturate at all-ones and never wrap.
  - Both are cleared only by reset.
- Reset, asynchronous: all shadow regs 0, state IDLE, rem 0, both counters 0.
  - Outputs during and immediately after reset: forward_a = forward_b = 00, stall = bubble = 0.
  - Reset mid-stall aborts the stall immediately.
- Simultaneous events:
  - Forwarding and stall may be active in the same cycle; they are independent.
  - A hazard detected in HOLD is ignored; the FSM is already stalling.

Test Plan:
- EX/MEM forward: cycle n: ex_dst=8, ex_regwrite=1, ex_valid=1. Cycle n+1: ex_rs=8, ex_rt=9 -> forward_a=10, forward_b=00, fwd_count increments by 1.
- MEM/WB forward and priority:
  - Write to r8, then a write to r9, then ex_rs=8, ex_rt=9 -> forward_a=01, forward_b=10.
  - Back-to-back writes to r8, then ex_rs=8 -> forward_a=10.
- Zero register and bubble: write to r0 with regwrite=1, then ex_rs=0 -> forward_a=00. A write to r5 with ex_valid=0, then ex_rs=5 -> 00.
- Load-use, LOAD_STALL_CYCLES=1: ex_memread=1, ex_dst=4, id_rt=4, id_valid=1 -> stall=bubble=1 for exactly 1 cycle. Next cycle, with the bubble in EX and id_rt=4, stall=0; the following cycle forward_b=01 when ex_rt=4. stall_count=1.
- Multi-cycle stall and flush, LOAD_STALL_CYCLES=3:
  - Same hazard -> stall high 3 consecutive cycles.
  - Repeat the hazard and assert flush in the 2nd stall cycle -> stall drops that cycle, FSM in IDLE.
  - Hazard and flush in the same cycle -> stall=0.
- Reset and saturation:
  - Assert reset asynchronously mid-HOLD -> stall=0 before the next clk edge, counters 0.
  - With CNT_W=4, 20 forwarding cycles -> fwd_count holds at 15.
